full_adder: RTL and testbench

- Registered, parameterizable ripple-carry adder: computes a + b + c and presents {carry, sum} one clock after the operands are sampled.
- WIDTH=1 default gives the classic 1-bit full adder (sum = a^b^c, carry = majority(a,b,c)).
- Used as a leaf arithmetic cell in datapaths needing a clean registered add with carry-out.

---
 rtl/full_adder_pkg.sv | 15 +
 rtl/full_adder_bit.sv | 13 +
 rtl/full_adder.sv | 61 ++++++
 tb/tb_full_adder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the registered ripple adder.
package full_adder_pkg;

   localparam int MAX_WIDTH = 64;

   typedef struct packed {
      logic                 carry;
      logic [MAX_WIDTH-1:0] sum;
   } result_t;

   function automatic int RESULT_W(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell, one link of the ripple chain.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {carry,sum} = a + b + c, 1-cycle latency.
module full_adder
   import full_adder_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             out_valid
);

   localparam int RW = RESULT_W(WIDTH);

   logic [RW-1:0]    w_c;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_valid;

   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("full_adder: WIDTH out of range");
   end

   assign w_c[0] = c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder_bit u_bit (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (w_c[i]),
         .s    (w_s[i]),
         .cout (w_c[i+1])
      );
   end

   // Result registers only load on valid input so idle cycles hold the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum   <= w_s;
            r_carry <= w_c[WIDTH];
         end
      end
   end

   assign sum       = r_sum;
   assign carry     = r_carry;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench driving WIDTH=1, 8 and 64 adders with a shared stimulus stream.
module tb_full_adder;
   import full_adder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        c = 1'b0;
   logic [0:0]  a1 = '0, b1 = '0, s1;
   logic [7:0]  a8 = '0, b8 = '0, s8;
   logic [63:0] a64 = '0, b64 = '0, s64;
   logic        co1, co8, co64;
   logic        ov1, ov8, ov64;

   int n_assert = 0;
   int n_fail   = 0;

   result_t q1[$], q8[$], q64[$];
   result_t h1 = '0, h8 = '0, h64 = '0;

   always #5 clk = ~clk;

   full_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a(a1), .b(b1), .c(c),
      .sum(s1), .carry(co1), .out_valid(ov1)
   );

   full_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a(a8), .b(b8), .c(c),
      .sum(s8), .carry(co8), .out_valid(ov8)
   );

   full_adder #(.WIDTH(64)) u_w64 (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .a(a64), .b(b64), .c(c),
      .sum(s64), .carry(co64), .out_valid(ov64)
   );

   function automatic result_t ref_add(input int w, input logic [63:0] x,
                                       input logic [63:0] y, input logic ci);
      logic [64:0] m, f;
      result_t r;
      m = (65'd1 << w) - 65'd1;
      f = ({1'b0, x} & m) + ({1'b0, y} & m) + {64'd0, ci};
      r.sum   = f[63:0] & m[63:0];
      r.carry = f[w];
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp(input int w, input bit eov, input result_t e,
                      input logic ov, input logic co, input logic [63:0] s);
      check($sformatf("w%0d_valid", w), {63'd0, ov}, {63'd0, eov});
      check($sformatf("w%0d_sum", w), s, e.sum);
      check($sformatf("w%0d_carry", w), {63'd0, co}, {63'd0, e.carry});
   endtask

   task automatic pop_all();
      if (q1.size() == 0 || q8.size() == 0 || q64.size() == 0) begin
         check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
         h1  = q1.pop_front();
         h8  = q8.pop_front();
         h64 = q64.pop_front();
      end
   endtask

   task automatic step(input bit v, input bit r, input logic [63:0] av,
                       input logic [63:0] bv, input logic cv);
      bit eov;
      in_valid = v;
      rst      = r;
      a1 = av[0:0];  b1 = bv[0:0];
      a8 = av[7:0];  b8 = bv[7:0];
      a64 = av;      b64 = bv;
      c = cv;
      eov = v && !r;
      if (r) begin
         q1.delete(); q8.delete(); q64.delete();
      end else if (v) begin
         q1.push_back(ref_add(1, av, bv, cv));
         q8.push_back(ref_add(8, av, bv, cv));
         q64.push_back(ref_add(64, av, bv, cv));
      end
      @(posedge clk);
      #1;
      if (r) begin
         h1 = '0; h8 = '0; h64 = '0;
      end else if (v) begin
         pop_all();
      end
      cmp(1, eov, h1, ov1, co1, {63'd0, s1});
      cmp(8, eov, h8, ov8, co8, s8);
      cmp(64, eov, h64, ov64, co64, s64);
   endtask

   initial begin
      // reset with live valid inputs
      step(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      step(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      step(1'b1, 1'b0, 64'd5, 64'd6, 1'b1);

      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, {63'd0, i[2]}, {63'd0, i[1]}, i[0]);
      end

      step(1'b1, 1'b0, 64'hFF, 64'h00, 1'b1);
      step(1'b1, 1'b0, 64'h7F, 64'h01, 1'b0);
      step(1'b1, 1'b0, 64'hFF, 64'hFF, 1'b1);

      step(1'b1, 1'b0, 64'd3, 64'd4, 1'b0);
      step(1'b0, 1'b0, 64'd9, 64'd9, 1'b0);
      step(1'b0, 1'b0, 64'd1, 64'd2, 1'b1);

      step(1'b1, 1'b0, 64'd10, 64'd20, 1'b1);
      step(1'b1, 1'b0, 64'd10, 64'd20, 1'b1);
      step(1'b1, 1'b1, 64'd99, 64'd99, 1'b1);
      step(1'b1, 1'b0, 64'd10, 64'd20, 1'b1);
      step(1'b1, 1'b0, 64'd10, 64'd20, 1'b1);

      for (int i = 0; i < 10000; i++) begin
         step(1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 99) == 0),
              {$urandom, $urandom}, {$urandom, $urandom},
              1'($urandom_range(0, 1)));
      end

      check("queue_empty", 64'(q1.size() + q8.size() + q64.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
